// File: rtl/bcp_axi_pkg.sv
// Shared AXI4 burst definitions for the BCP burst slave memory.
package bcp_axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    // Address of the following beat; arithmetic is done on 32 bits and the
    // caller truncates to its own address width (modulo 2^ADDR_WIDTH).
    function automatic logic [31:0] axi_next_addr(input logic [31:0] addr,
                                                  input logic [2:0]  size,
                                                  input logic [7:0]  len,
                                                  input burst_t      burst);
        logic [31:0] b;
        logic [31:0] blk;
        logic [31:0] aligned;
        logic [31:0] result;
        b       = 32'd1 << size;
        aligned = addr & ~(b - 32'd1);
        blk     = b * ({24'd0, len} + 32'd1);
        case (burst)
            BURST_FIXED: result = addr;
            BURST_INCR:  result = aligned + b;
            BURST_WRAP:  result = (addr & ~(blk - 32'd1)) | ((aligned + b) & (blk - 32'd1));
            default:     result = addr;
        endcase
        return result;
    endfunction

    // Request that the memory refuses: reserved burst, beat wider than the
    // bus, or a WRAP whose length is not 2, 4, 8 or 16 beats.
    function automatic logic axi_req_err(input logic [2:0] size,
                                         input logic [7:0] len,
                                         input burst_t     burst,
                                         input logic [2:0] max_size);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (burst == BURST_RSVD) || (size > max_size) ||
               ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

endpackage

// File: rtl/bcp_sdp_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port.
// A read and write to the same word in one cycle returns the old word.
module bcp_sdp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [AW-1:0]           waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    re,
    input  logic [AW-1:0]           raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem_r [0:(1<<AW)-1];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Byte-lane writes; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_WIDTH/8; i++) begin
            if (we && wstrb[i]) begin
                mem_r[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // Read register, loaded only when a read is issued so data holds during stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/bcp_axi_burst_mem.sv
// AXI4 burst slave memory: independent write and read FSMs over a dual-port RAM.
module bcp_axi_burst_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);
    import bcp_axi_pkg::*;

    localparam int         STRB_W   = DATA_WIDTH / 8;
    localparam int         OFF_W    = $clog2(STRB_W);
    localparam int         WORD_AW  = ADDR_WIDTH - OFF_W;
    localparam logic [2:0] MAX_SIZE = 3'(OFF_W);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    // Write channel state
    wstate_t               wstate_r;
    logic [ID_WIDTH-1:0]   wid_r;
    logic [ADDR_WIDTH-1:0] waddr_r;
    logic [7:0]            wlen_r;
    logic [7:0]            wbeat_r;
    logic [2:0]            wsize_r;
    burst_t                wburst_r;
    logic                  wreq_err_r;
    logic                  wlast_err_r;
    logic                  awready_r;
    logic                  wready_r;
    logic                  bvalid_r;
    logic [1:0]            bresp_r;

    // Read channel state
    rstate_t               rstate_r;
    logic [ID_WIDTH-1:0]   rid_r;
    logic [ADDR_WIDTH-1:0] raddr_r;
    logic [7:0]            rlen_r;
    logic [7:0]            rbeat_r;
    logic [2:0]            rsize_r;
    burst_t                rburst_r;
    logic                  rerr_r;
    logic                  arready_r;
    logic                  rvalid_r;
    logic                  rlast_r;
    logic [1:0]            rresp_r;

    logic                  aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
    logic                  w_final_s, wlast_bad_s;
    logic [ADDR_WIDTH-1:0] wnext_addr_s, rnext_addr_s, ram_raddr_s;
    logic                  ram_we_s, ram_re_s;
    logic [DATA_WIDTH-1:0] ram_rdata_s;

    assign aw_hs_s      = AWVALID && awready_r;
    assign w_hs_s       = WVALID && wready_r;
    assign b_hs_s       = bvalid_r && BREADY;
    assign ar_hs_s      = ARVALID && arready_r;
    assign r_hs_s       = rvalid_r && RREADY;
    assign w_final_s    = (wbeat_r == wlen_r);
    assign wlast_bad_s  = (WLAST != w_final_s);
    assign wnext_addr_s = ADDR_WIDTH'(axi_next_addr(32'(waddr_r), wsize_r, wlen_r, wburst_r));
    assign rnext_addr_s = ADDR_WIDTH'(axi_next_addr(32'(raddr_r), rsize_r, rlen_r, rburst_r));
    assign ram_we_s     = w_hs_s && !wreq_err_r;
    assign ram_re_s     = ar_hs_s || (r_hs_s && !rlast_r);
    assign ram_raddr_s  = ar_hs_s ? ARADDR : rnext_addr_s;

    bcp_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (WORD_AW)
    ) u_ram (
        .clk   (ACLK),
        .rst   (ARESET),
        .we    (ram_we_s),
        .wstrb (WSTRB),
        .waddr (waddr_r[ADDR_WIDTH-1:OFF_W]),
        .wdata (WDATA),
        .re    (ram_re_s),
        .raddr (ram_raddr_s[ADDR_WIDTH-1:OFF_W]),
        .rdata (ram_rdata_s)
    );

    // Write FSM: accept AW, take len+1 beats, then hold the B response until BREADY.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wstate_r    <= W_IDLE;
            wid_r       <= {ID_WIDTH{1'b0}};
            waddr_r     <= {ADDR_WIDTH{1'b0}};
            wlen_r      <= 8'd0;
            wbeat_r     <= 8'd0;
            wsize_r     <= 3'd0;
            wburst_r    <= BURST_FIXED;
            wreq_err_r  <= 1'b0;
            wlast_err_r <= 1'b0;
            awready_r   <= 1'b0;
            wready_r    <= 1'b0;
            bvalid_r    <= 1'b0;
            bresp_r     <= RESP_OKAY;
        end else begin
            case (wstate_r)
                W_IDLE: begin
                    awready_r <= 1'b1;
                    if (aw_hs_s) begin
                        wid_r       <= AWID;
                        waddr_r     <= AWADDR;
                        wlen_r      <= AWLEN;
                        wsize_r     <= AWSIZE;
                        wburst_r    <= burst_t'(AWBURST);
                        wreq_err_r  <= axi_req_err(AWSIZE, AWLEN, burst_t'(AWBURST), MAX_SIZE);
                        wlast_err_r <= 1'b0;
                        wbeat_r     <= 8'd0;
                        awready_r   <= 1'b0;
                        wready_r    <= 1'b1;
                        wstate_r    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs_s) begin
                        waddr_r <= wnext_addr_s;
                        wbeat_r <= wbeat_r + 8'd1;
                        if (wlast_bad_s) begin
                            wlast_err_r <= 1'b1;
                        end
                        if (w_final_s) begin
                            wready_r <= 1'b0;
                            bvalid_r <= 1'b1;
                            bresp_r  <= (wreq_err_r || wlast_err_r || wlast_bad_s) ? RESP_SLVERR : RESP_OKAY;
                            wstate_r <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_hs_s) begin
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        wstate_r  <= W_IDLE;
                    end
                end
                default: begin
                    wstate_r <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: accept AR, present one beat per R handshake, RLAST on beat len.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rstate_r  <= R_IDLE;
            rid_r     <= {ID_WIDTH{1'b0}};
            raddr_r   <= {ADDR_WIDTH{1'b0}};
            rlen_r    <= 8'd0;
            rbeat_r   <= 8'd0;
            rsize_r   <= 3'd0;
            rburst_r  <= BURST_FIXED;
            rerr_r    <= 1'b0;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rresp_r   <= RESP_OKAY;
        end else begin
            case (rstate_r)
                R_IDLE: begin
                    arready_r <= 1'b1;
                    if (ar_hs_s) begin
                        rid_r     <= ARID;
                        raddr_r   <= ARADDR;
                        rlen_r    <= ARLEN;
                        rsize_r   <= ARSIZE;
                        rburst_r  <= burst_t'(ARBURST);
                        rerr_r    <= axi_req_err(ARSIZE, ARLEN, burst_t'(ARBURST), MAX_SIZE);
                        rresp_r   <= axi_req_err(ARSIZE, ARLEN, burst_t'(ARBURST), MAX_SIZE) ? RESP_SLVERR : RESP_OKAY;
                        rbeat_r   <= 8'd0;
                        rlast_r   <= (ARLEN == 8'd0);
                        rvalid_r  <= 1'b1;
                        arready_r <= 1'b0;
                        rstate_r  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs_s) begin
                        if (rlast_r) begin
                            rvalid_r  <= 1'b0;
                            rlast_r   <= 1'b0;
                            arready_r <= 1'b1;
                            rstate_r  <= R_IDLE;
                        end else begin
                            raddr_r <= rnext_addr_s;
                            rbeat_r <= rbeat_r + 8'd1;
                            rlast_r <= ((rbeat_r + 8'd1) == rlen_r);
                        end
                    end
                end
                default: begin
                    rstate_r <= R_IDLE;
                end
            endcase
        end
    end

    assign AWREADY = awready_r;
    assign WREADY  = wready_r;
    assign BID     = wid_r;
    assign BRESP   = bresp_r;
    assign BVALID  = bvalid_r;
    assign ARREADY = arready_r;
    assign RID     = rid_r;
    assign RDATA   = rerr_r ? {DATA_WIDTH{1'b0}} : ram_rdata_s;
    assign RRESP   = rresp_r;
    assign RLAST   = rlast_r;
    assign RVALID  = rvalid_r;

endmodule

// File: tb/tb_bcp_axi_burst_mem.sv
// Randomized self-checking bench for bcp_axi_burst_mem against a byte-array model.
`timescale 1ns/1ps
module tb_bcp_axi_burst_mem;

    localparam int IW = 4;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic [IW-1:0] AWID = '0, ARID = '0;
    logic [11:0]   AWADDR = '0, ARADDR = '0;
    logic [7:0]    AWLEN = '0, ARLEN = '0;
    logic [2:0]    AWSIZE = '0, ARSIZE = '0;
    logic [1:0]    AWBURST = '0, ARBURST = '0;
    logic          AWVALID = 1'b0, ARVALID = 1'b0;
    logic          AWREADY, ARREADY;
    logic [31:0]   WDATA = '0;
    logic [3:0]    WSTRB = '0;
    logic          WLAST = 1'b0, WVALID = 1'b0, WREADY;
    logic [IW-1:0] BID, RID;
    logic [1:0]    BRESP, RRESP;
    logic          BVALID, BREADY = 1'b0;
    logic [31:0]   RDATA;
    logic          RLAST, RVALID, RREADY = 1'b0;

    always #5 ACLK = ~ACLK;

    bcp_axi_burst_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .ID_WIDTH(IW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: memory as a flat byte array, plus expected response queues
    logic [7:0] mb [0:4095];
    logic [31:0] wd [0:255];
    logic [3:0]  ws [0:255];

    typedef struct { logic [IW-1:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rexp_t;
    typedef struct { logic [IW-1:0] id; logic [1:0] resp; } bexp_t;
    rexp_t exp_r[$];
    bexp_t exp_b[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_err(input logic [2:0] size, input logic [7:0] len, input logic [1:0] burst);
        return (burst == 2'd3) || (size > 3'd2) ||
               ((burst == 2'd2) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    endfunction

    // Byte address of beat i, straight from the burst definitions
    function automatic logic [11:0] beat_addr(input logic [11:0] start, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst, input int i);
        int b, al, blk, base;
        b  = 1 << size;
        al = int'(start) & ~(b - 1);
        if (burst == 2'd0 || i == 0) return start;
        if (burst == 2'd2) begin
            blk  = b * (int'(len) + 1);
            base = int'(start) & ~(blk - 1);
            return 12'(base + ((al - base + i * b) % blk));
        end
        return 12'(al + i * b);
    endfunction

    function automatic logic [31:0] model_word(input logic [11:0] a);
        int w;
        w = int'(a) & ~3;
        return {mb[w+3], mb[w+2], mb[w+1], mb[w]};
    endfunction

    // Compare process: every cycle a response is valid it must equal the model's head entry
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (RVALID) begin
                if (exp_r.size() == 0) begin
                    check("r_unexpected", 64'd1, 64'd0);
                end else begin
                    check("rid", 64'(RID), 64'(exp_r[0].id));
                    check("rdata", 64'(RDATA), 64'(exp_r[0].data));
                    check("rresp", 64'(RRESP), 64'(exp_r[0].resp));
                    check("rlast", 64'(RLAST), 64'(exp_r[0].last));
                    if (RREADY) void'(exp_r.pop_front());
                end
            end
            if (BVALID) begin
                if (exp_b.size() == 0) begin
                    check("b_unexpected", 64'd1, 64'd0);
                end else begin
                    check("bid", 64'(BID), 64'(exp_b[0].id));
                    check("bresp", 64'(BRESP), 64'(exp_b[0].resp));
                    if (BREADY) void'(exp_b.pop_front());
                end
            end
        end
    end

    // Write burst from wd/ws; bad_beat flips WLAST on that beat; abort_beat asserts reset there
    task automatic do_write(input logic [IW-1:0] id, input logic [11:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int bad_beat, input int abort_beat);
        logic err;
        int n;
        logic [11:0] a;
        bexp_t e;
        err    = is_err(size, len, burst);
        e.id   = id;
        e.resp = (err || (bad_beat >= 0 && bad_beat <= int'(len))) ? 2'd2 : 2'd0;
        exp_b.push_back(e);
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!AWREADY && n < 100) begin @(negedge ACLK); n++; end
        if (!AWREADY) begin check("aw_timeout", 64'd0, 64'd1); AWVALID = 1'b0; return; end
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            WDATA = wd[i]; WSTRB = ws[i];
            WLAST = ((i == int'(len)) != (i == bad_beat));
            WVALID = 1'b1;
            if (i == abort_beat) begin
                ARESET = 1'b1;
                exp_r.delete(); exp_b.delete();
                WVALID = 1'b0;
                return;
            end
            n = 0;
            @(negedge ACLK);
            while (!WREADY && n < 100) begin @(negedge ACLK); n++; end
            if (!WREADY) begin check("w_timeout", 64'd0, 64'd1); WVALID = 1'b0; return; end
            @(posedge ACLK);
            a = beat_addr(addr, size, len, burst, i);
            if (!err) begin
                for (int j = 0; j < 4; j++) begin
                    if (ws[i][j]) mb[(int'(a) & ~3) + j] = wd[i][8*j +: 8];
                end
            end
            #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        check("bvalid_latency", 64'(BVALID), 64'd1);
        n = int'($urandom_range(0, 2));
        for (int k = 0; k < n; k++) begin @(posedge ACLK); #1; end
        BREADY = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!BVALID && n < 100) begin @(negedge ACLK); n++; end
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        check("aw_ready_after_b", 64'({BVALID, AWREADY}), 64'd1);
    endtask

    task automatic start_read(input logic [IW-1:0] id, input logic [11:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        logic err;
        int n;
        rexp_t e;
        err = is_err(size, len, burst);
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!ARREADY && n < 100) begin @(negedge ACLK); n++; end
        if (!ARREADY) check("ar_timeout", 64'd0, 64'd1);
        for (int i = 0; i <= int'(len); i++) begin
            e.id   = id;
            e.data = err ? 32'd0 : model_word(beat_addr(addr, size, len, burst, i));
            e.resp = err ? 2'd2 : 2'd0;
            e.last = (i == int'(len));
            exp_r.push_back(e);
        end
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        check("r_latency", 64'(RVALID), 64'd1);
    endtask

    // mode 0: RREADY held high, 1: toggling, 2: random
    task automatic do_read(input logic [IW-1:0] id, input logic [11:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode);
        int got, n;
        start_read(id, addr, len, size, burst);
        got = 0; n = 0;
        while (got <= int'(len) && n < 2000) begin
            RREADY = (mode == 0) ? 1'b1 : (mode == 1) ? n[0] : 1'($urandom_range(0, 1));
            @(negedge ACLK);
            if (RVALID && RREADY) got++;
            @(posedge ACLK); #1;
            n++;
        end
        RREADY = 1'b0;
        check("r_beats", 64'(got), 64'(int'(len) + 1));
        check("r_done", 64'({RVALID, ARREADY}), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] a1, a2, a3;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [11:0] addr;
        int bad;
        for (int i = 0; i < 4096; i++) mb[i] = 8'd0;

        // Reset state
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("reset_ready", 64'({AWREADY, WREADY, ARREADY}), 64'd0);
        check("reset_valid", 64'({BVALID, RVALID, RLAST}), 64'd0);
        check("reset_data", 64'({RDATA, RID, RRESP, BID, BRESP}), 64'd0);
        ARESET = 1'b0;
        #1 check("ready_before_edge", 64'({AWREADY, ARREADY}), 64'd0);
        @(posedge ACLK); #1;
        check("ready_after_edge", 64'({AWREADY, ARREADY}), 64'd3);

        // Fill the whole memory so model and RAM start identical
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            do_write(4'h1, 12'(blk * 1024), 8'd255, 3'd2, 2'd1, -1, -1);
        end

        // INCR len 7, data 1..8
        for (int i = 0; i < 8; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        do_write(4'h3, 12'h000, 8'd7, 3'd2, 2'd1, -1, -1);
        check("model_incr_last", 64'(model_word(12'h01C)), 64'd8);
        do_read(4'h3, 12'h000, 8'd7, 3'd2, 2'd1, 0);

        // WRAP len 3 at 0x38
        a1 = beat_addr(12'h038, 3'd2, 8'd3, 2'd2, 1);
        a2 = beat_addr(12'h038, 3'd2, 8'd3, 2'd2, 2);
        a3 = beat_addr(12'h038, 3'd2, 8'd3, 2'd2, 3);
        check("model_wrap_order", 64'({a1, a2, a3}), 64'h03C030034);
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA + 32'(i); ws[i] = 4'hF; end
        do_write(4'h4, 12'h038, 8'd3, 3'd2, 2'd2, -1, -1);
        check("model_wrap_word30", 64'(model_word(12'h030)), 64'hC);
        do_read(4'h4, 12'h038, 8'd3, 3'd2, 2'd2, 2);

        // FIXED len 3 with one byte lane per beat
        wd[0] = 32'h0000_0011; ws[0] = 4'h1;
        wd[1] = 32'h0000_2200; ws[1] = 4'h2;
        wd[2] = 32'h0033_0000; ws[2] = 4'h4;
        wd[3] = 32'h4400_0000; ws[3] = 4'h8;
        do_write(4'h5, 12'h010, 8'd3, 3'd2, 2'd0, -1, -1);
        check("model_fixed_word", 64'(model_word(12'h010)), 64'h44332211);
        do_read(4'h5, 12'h010, 8'd0, 3'd2, 2'd1, 0);

        // 8-beat read with RREADY toggling
        do_read(4'h6, 12'h000, 8'd7, 3'd2, 2'd1, 1);

        // Early WLAST on beat 2 of 4: data still lands, SLVERR
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hE0 + 32'(i); ws[i] = 4'hF; end
        do_write(4'h7, 12'h100, 8'd3, 3'd2, 2'd1, 1, -1);
        do_read(4'h7, 12'h100, 8'd3, 3'd2, 2'd1, 0);

        // Error requests: reserved burst and oversize beat
        do_read(4'h8, 12'h000, 8'd3, 3'd2, 2'd3, 0);
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(4'h9, 12'h040, 8'd3, 3'd3, 2'd1, -1, -1);
        do_read(4'h9, 12'h040, 8'd3, 3'd2, 2'd1, 0);

        // Reset during beat 3 of 8 with a stalled read in flight
        start_read(4'hA, 12'h200, 8'd7, 3'd2, 2'd1);
        for (int i = 0; i < 8; i++) begin wd[i] = 32'hF00 + 32'(i); ws[i] = 4'hF; end
        do_write(4'hB, 12'h300, 8'd7, 3'd2, 2'd1, -1, 2);
        @(negedge ACLK);
        check("mid_reset_outputs", 64'({RVALID, BVALID, AWREADY, WREADY, ARREADY}), 64'd0);
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        for (int i = 0; i < 8; i++) begin wd[i] = 32'hB00 + 32'(i); ws[i] = 4'hF; end
        do_write(4'hC, 12'h400, 8'd7, 3'd2, 2'd1, -1, -1);
        do_read(4'hC, 12'h400, 8'd7, 3'd2, 2'd1, 0);
        do_read(4'hD, 12'h300, 8'd7, 3'd2, 2'd1, 0);

        // Randomized bursts
        for (int t = 0; t < 40; t++) begin
            burst = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            size  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            if (burst == 2'd2) begin
                case ($urandom_range(0, 4))
                    0: len = 8'd1;
                    1: len = 8'd3;
                    2: len = 8'd7;
                    3: len = 8'd15;
                    default: len = 8'd2;
                endcase
            end else begin
                len = 8'($urandom_range(0, 15));
            end
            addr = 12'($urandom_range(0, 4095));
            if (burst == 2'd2) addr = addr & ~12'((1 << size) - 1);
            for (int i = 0; i <= int'(len); i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
            bad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(len))) : -1;
            do_write(4'($urandom_range(0, 15)), addr, len, size, burst, bad, -1);
            do_read(4'($urandom_range(0, 15)), addr, len, size, burst, int'($urandom_range(0, 2)));
        end

        repeat (2) @(posedge ACLK);
        check("exp_r_drained", 64'(exp_r.size()), 64'd0);
        check("exp_b_drained", 64'(exp_b.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcp_axi_burst_mem.md
# bcp_axi_burst_mem
Parametrised AXI4 burst slave memory for the BCP accelerator's clause/assignment store. It succeeds the fixed 32-bit, INCR-only slave memory with configurable data width and depth, and adds FIXED and WRAP bursts, narrow transfers and SLVERR reporting. Write and read channels run concurrently. It sits behind the host AXI4 master port; the AXI4-Lite control registers are a separate block.
## Interface
- DATA_WIDTH, 32, data bus width in bits; legal values are 32, 64 and 128.
- ADDR_WIDTH, 12, byte-address width; memory depth is 2^ADDR_WIDTH / (DATA_WIDTH/8) words.
- ID_WIDTH, 4, transaction ID width.
- ACLK  in  1  single clock; all logic is on its rising edge.
- ARESET  in  1  reset, asynchronous and active-high.
- AWID/ARID  in  ID_WIDTH  write/read request ID.
- AWADDR/ARADDR  in  ADDR_WIDTH  byte start address.
- AWLEN/ARLEN  in  8  beats minus 1.
- AWSIZE/ARSIZE  in  3  log2 of bytes per beat.
- AWBURST/ARBURST  in  2  burst type: 0 = FIXED, 1 = INCR, 2 = WRAP, 3 = reserved.
- AWVALID/ARVALID  in  1 each; AWREADY/ARREADY  out  1 each: address handshakes.
- WDATA  in  DATA_WIDTH  write data.
- WSTRB  in  DATA_WIDTH/8  byte enables.
- WLAST  in  1  last write beat.
- WVALID in 1, WREADY out 1: write data handshake.
- BID  out  ID_WIDTH  write response ID.
- BRESP  out  2  write response: 0 = OKAY, 2 = SLVERR.
- BVALID out 1, BREADY in 1: write response handshake.
- RID  out  ID_WIDTH  read data ID.
- RDATA  out  DATA_WIDTH  read data, always the full word lane.
- RRESP  out  2  read response.
- RLAST  out  1  last read beat.
- RVALID out 1, RREADY in 1: read data handshake.
## Operation
- Write FSM: W_IDLE → W_DATA → W_RESP → W_IDLE.
- W_IDLE: AWREADY=1. On the AW handshake, latch id, addr, len, size and burst, clear the beat counter, go to W_DATA.
- W_DATA: WREADY=1. On each W handshake, write the WSTRB-enabled bytes of WDATA at word addr>>log2(DATA_WIDTH/8), then advance addr and the beat counter. After beat len, go to W_RESP.
- W_RESP: BVALID=1, BID=latched id, held until BREADY; then return to W_IDLE.
- Read FSM: R_IDLE → R_DATA → R_IDLE.
- R_IDLE: ARREADY=1. On the AR handshake, latch the request and issue a RAM read at ARADDR.
- R_DATA: RVALID=1, RID=latched id, RLAST=1 on beat len. On each R handshake that is not the last, issue the read at the next address. After the last handshake, return to R_IDLE.
- Next address, computed on a size-aligned address with b = 2^size:
  - FIXED: addr unchanged.
  - INCR: aligned addr + b.
  - WRAP: B = b·(len+1); result = (addr & ~(B−1)) | ((addr+b) & (B−1)).
  - All address arithmetic is modulo 2^ADDR_WIDTH; there is no 4 KB boundary check.
- Error requests: burst=3, size > log2(DATA_WIDTH/8), or WRAP with len ∉ {1,3,7,15}.
  - Writes: all beats are accepted, nothing is written, BRESP=SLVERR.
  - Reads: all beats are returned with RDATA=0 and RRESP=SLVERR.
- WLAST mismatch (asserted before beat len, or absent on beat len): the data is still written, BRESP=SLVERR. The beat count, not WLAST, ends the burst.
- The write and read FSMs are independent. A same-cycle write and read to the same word returns the old data.
## Timing
- While ARESET is high, every output is 0. AWREADY and ARREADY rise on the first ACLK edge after release. RAM contents are not reset.
- Read latency: AR handshake at cycle N → first RVALID at N+1. One beat per cycle under continuous RREADY.
- Write: one beat per cycle. BVALID is asserted the cycle after the last W handshake.
- RDATA, RID, RRESP and RLAST are held stable while RVALID=1 and RREADY=0. BID and BRESP are held stable while BVALID=1 and BREADY=0.
- AWREADY is 0 in W_DATA and W_RESP. ARREADY is 0 in R_DATA. Only one burst is outstanding per direction.
- ARESET asserted mid-burst: both FSMs return to idle immediately and the in-flight burst gets no B or R response.
## Structure
- Package bcp_axi_pkg holds: the burst_t enum (FIXED/INCR/WRAP/RSVD), the RESP_OKAY/RESP_SLVERR constants, and the function axi_next_addr(addr, size, len, burst).
- One sub-module, bcp_sdp_ram: simple dual-port RAM with a byte-enabled write port and a registered read port.
## Test plan
- INCR, len=7, size=2, DATA_WIDTH=32, addr 0x000, data 1..8 → BRESP=OKAY; read-back equals 1..8; RLAST only on beat 8.
- WRAP, len=3, size=2, addr 0x38, data A..D → words written at 0x38, 0x3C, 0x30, 0x34; read-back order is the same.
- FIXED, len=3, addr 0x10, WSTRB=0x1,0x2,0x4,0x8 carrying bytes 11,22,33,44 → word 0x10 reads 0x44332211.
- RREADY toggling every other cycle on an 8-beat read → RDATA stable while stalled; 8 beats in order.
- Early WLAST on beat 2 of 4 → all 4 beats written, BRESP=SLVERR. Burst=3 read → RRESP=SLVERR, RDATA=0.
- ARESET asserted during beat 3 of 8 → RVALID/BVALID=0 next cycle; no response issued; a fresh burst afterwards completes with OKAY.
